// File: rtl/cnv_pkg.sv
// Shared types and defaults for the convolution window controller.
// Holds the FSM encoding and the default image geometry.
package cnv_pkg;

  localparam int DEF_WIDTH  = 128;
  localparam int DEF_HEIGHT = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/cnv_if.sv
// Scan bundle between the frame FSM and the row/column counter.
// The FSM side steps/clears the scan and reads back the position.
interface cnv_if #(
  parameter int ROW_W = 7,
  parameter int COL_W = 7
);

  logic             en;
  logic             clr;
  logic             last;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;

  modport master (
    output en, clr,
    input  row, col, last
  );

  modport slave (
    input  en, clr,
    output row, col, last
  );

endinterface

// File: rtl/cnv_scan_cnt.sv
// Row-major window-centre scan counter.
// Parks on the final pixel instead of wrapping past the frame.
module cnv_scan_cnt
  import cnv_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT
) (
  input logic  clk,
  input logic  rst,
  cnv_if.slave s
);

  localparam int COL_W = $clog2(WIDTH);
  localparam int ROW_W = $clog2(HEIGHT);

  localparam logic [COL_W-1:0] COL_MAX =
    COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_MAX =
    ROW_W'(HEIGHT - 1);

  always_comb
    s.last = (s.row == ROW_MAX) &&
             (s.col == COL_MAX);

  always_ff @(posedge clk) begin
    if (rst || s.clr) begin
      s.row <= '0;
      s.col <= '0;
    end else if (s.en && !s.last) begin
      if (s.col == COL_MAX) begin
        s.col <= '0;
        s.row <= s.row + ROW_W'(1);
      end else begin
        s.col <= s.col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/cnv_ctrl.sv
// Frame controller: issues one window per pixel to the MAC array
// and tracks returned results until the frame is complete.
module cnv_ctrl
  import cnv_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       stall_i,
  input  logic                       mac_vld_i,
  output logic                       ctrl_data_run,
  output logic [$clog2(HEIGHT)-1:0]  row,
  output logic [$clog2(WIDTH)-1:0]   col,
  output logic                       busy_o,
  output logic                       frame_done,
  output logic                       err_o
);

  localparam int COL_W = $clog2(WIDTH);
  localparam int ROW_W = $clog2(HEIGHT);
  localparam int CNT_W = $clog2(WIDTH * HEIGHT + 1);

  localparam logic [CNT_W-1:0] TOTAL =
    CNT_W'(WIDTH * HEIGHT);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] iss_cnt;
  logic [CNT_W-1:0] ret_cnt;
  logic [CNT_W-1:0] outstanding;
  logic             cnt_clr;
  logic             active;
  logic             mac_ok;
  logic             last_ret;

  cnv_if #(
    .ROW_W (ROW_W),
    .COL_W (COL_W)
  ) scan ();

  cnv_scan_cnt #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_scan (
    .clk (clk),
    .rst (rst),
    .s   (scan)
  );

  assign ctrl_data_run = (state == RUN) && !stall_i;
  assign busy_o        = (state != IDLE);
  assign frame_done    = (state == DONE);
  assign row           = scan.row;
  assign col           = scan.col;

  assign cnt_clr  = abort || ((state == IDLE) && start);
  assign scan.en  = ctrl_data_run;
  assign scan.clr = cnt_clr;

  assign outstanding = iss_cnt - ret_cnt;
  assign active      = (state == RUN) || (state == DRAIN);

  // A same-cycle issue counts as outstanding for a zero-latency MAC.
  assign mac_ok   = mac_vld_i && active &&
                    ((outstanding != '0) || ctrl_data_run);
  assign last_ret = mac_ok &&
                    ((ret_cnt + CNT_W'(1)) == TOTAL);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (start) state_nxt = RUN;
      RUN:
        if (ctrl_data_run && scan.last)
          state_nxt = last_ret ? DONE : DRAIN;
      DRAIN:
        if (last_ret) state_nxt = DONE;
      DONE:
        state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      iss_cnt <= '0;
      ret_cnt <= '0;
    end else begin
      if (ctrl_data_run) iss_cnt <= iss_cnt + CNT_W'(1);
      if (mac_ok)        ret_cnt <= ret_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                      err_o <= 1'b0;
    else if (mac_vld_i && !mac_ok) err_o <= 1'b1;
  end

endmodule

// File: tb/tb_cnv_ctrl.sv
// Scoreboard bench for cnv_ctrl at 4x3 with a 2-cycle MAC model.
// Stimulus queues expected issues/frame_done; a monitor checks them.
module tb_cnv_ctrl;
  import cnv_pkg::*;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int RW = $clog2(H);
  localparam int CW = $clog2(W);

  typedef struct {
    int cyc;
    int row;
    int col;
  } iss_t;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic stall = 1'b0;
  logic spur  = 1'b0;
  logic busy, done, err, mac_vld;
  logic d1, d2;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  iss_t iss_q[$];
  int   done_q[$];

  cnv_if #(.ROW_W(RW), .COL_W(CW)) bus ();

  assign bus.clr  = rst;
  assign bus.last = (bus.row == RW'(H - 1)) &&
                    (bus.col == CW'(W - 1));

  cnv_ctrl #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .stall_i       (stall),
    .mac_vld_i     (mac_vld),
    .ctrl_data_run (bus.en),
    .row           (bus.row),
    .col           (bus.col),
    .busy_o        (busy),
    .frame_done    (done),
    .err_o         (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // MAC lane model: result two cycles after each issued window
  always @(posedge clk) begin
    if (rst) begin
      d1 <= 1'b0;
      d2 <= 1'b0;
    end else begin
      d1 <= bus.en;
      d2 <= d1;
    end
  end

  assign mac_vld = d2 | spur;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d",
               nm, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(int c);
    while (cyc < c) step();
  endtask

  task automatic push_frame(int first, int slo, int shi, int n);
    int   c;
    iss_t e;
    c = first;
    for (int i = 0; i < n; i++) begin
      while (c >= slo && c <= shi) c++;
      e.cyc = c;
      e.row = i / W;
      e.col = i % W;
      iss_q.push_back(e);
      c++;
    end
  endtask

  always @(negedge clk) begin : monitor
    iss_t e;
    int   dc;
    if (bus.en === 1'b1) begin
      if (iss_q.size() == 0) begin
        chk("unexpected_issue", 32'd1, 32'd0);
      end else begin
        e = iss_q.pop_front();
        chk("issue_cycle", cyc, e.cyc);
        chk("issue_row", 32'(bus.row), e.row);
        chk("issue_col", 32'(bus.col), e.col);
      end
    end
    if (done !== 1'b0) begin
      if (done_q.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        dc = done_q.pop_front();
        chk("done_cycle", cyc, dc);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin : stim
    int b;

    run_to(2);
    @(negedge clk);
    chk("rst_run", 32'(bus.en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_row", 32'(bus.row), 0);
    chk("rst_col", 32'(bus.col), 0);
    run_to(3);
    rst = 1'b0;

    // plain frame
    run_to(4);
    b = cyc;
    push_frame(b + 1, -1, -1, W * H);
    done_q.push_back(b + 15);
    start = 1'b1;
    run_to(b + 1);
    start = 1'b0;
    run_to(b + 15);
    @(negedge clk);
    chk("f1_busy15", 32'(busy), 1);
    run_to(b + 16);
    @(negedge clk);
    chk("f1_busy16", 32'(busy), 0);
    chk("f1_row_hold", 32'(bus.row), H - 1);
    chk("f1_col_hold", 32'(bus.col), W - 1);
    run_to(b + 18);

    // stall cycles 3..5
    b = cyc;
    push_frame(b + 1, b + 3, b + 5, W * H);
    done_q.push_back(b + 18);
    start = 1'b1;
    run_to(b + 1);
    start = 1'b0;
    run_to(b + 3);
    stall = 1'b1;
    for (int k = 3; k <= 5; k++) begin
      run_to(b + k);
      @(negedge clk);
      chk("stall_run", 32'(bus.en), 0);
      chk("stall_row", 32'(bus.row), 0);
      chk("stall_col", 32'(bus.col), 2);
    end
    run_to(b + 6);
    stall = 1'b0;
    run_to(b + 20);
    chk("stall_q_empty", iss_q.size(), 0);

    // abort at cycle 7
    b = cyc;
    push_frame(b + 1, -1, -1, 7);
    start = 1'b1;
    run_to(b + 1);
    start = 1'b0;
    run_to(b + 7);
    abort = 1'b1;
    run_to(b + 8);
    abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_run", 32'(bus.en), 0);
    chk("abort_row", 32'(bus.row), 0);
    chk("abort_col", 32'(bus.col), 0);
    chk("abort_err_pre", 32'(err), 0);
    run_to(b + 10);
    @(negedge clk);
    chk("abort_err_late", 32'(err), 1);
    run_to(b + 12);
    rst = 1'b1;
    run_to(b + 13);
    rst = 1'b0;

    // reset mid-frame at cycle 6
    run_to(b + 14);
    b = cyc;
    push_frame(b + 1, -1, -1, 6);
    start = 1'b1;
    run_to(b + 1);
    start = 1'b0;
    run_to(b + 6);
    rst = 1'b1;
    run_to(b + 7);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_run", 32'(bus.en), 0);
    chk("mrst_row", 32'(bus.row), 0);
    chk("mrst_col", 32'(bus.col), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_done", 32'(done), 0);
    chk("mrst_err", 32'(err), 0);
    run_to(b + 8);
    b = cyc;
    push_frame(b + 1, -1, -1, W * H);
    done_q.push_back(b + 15);
    start = 1'b1;
    run_to(b + 1);
    start = 1'b0;
    run_to(b + 17);
    chk("mrst_q_empty", iss_q.size(), 0);

    // spurious result in IDLE
    b = cyc;
    spur = 1'b1;
    run_to(b + 1);
    spur = 1'b0;
    @(negedge clk);
    chk("spur_err", 32'(err), 1);
    run_to(b + 2);
    b = cyc;
    push_frame(b + 1, -1, -1, W * H);
    done_q.push_back(b + 15);
    start = 1'b1;
    run_to(b + 1);
    start = 1'b0;
    run_to(b + 17);
    @(negedge clk);
    chk("spur_err_sticky", 32'(err), 1);
    chk("spur_done_q", done_q.size(), 0);

    // start held high across two frames
    run_to(b + 18);
    b = cyc;
    push_frame(b + 1, -1, -1, W * H);
    push_frame(b + 17, -1, -1, W * H);
    done_q.push_back(b + 15);
    done_q.push_back(b + 31);
    start = 1'b1;
    run_to(b + 16);
    @(negedge clk);
    chk("held_idle16", 32'(busy), 0);
    run_to(b + 17);
    @(negedge clk);
    chk("held_busy17", 32'(busy), 1);
    run_to(b + 18);
    start = 1'b0;
    run_to(b + 34);

    chk("final_iss_q", iss_q.size(), 0);
    chk("final_done_q", done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/cnv_ctrl.md
CNV_CTRL -- requirements
Module: cnv_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 128, image width in pixels (>=2).
REQ-002 SHALL have parameter HEIGHT, default 128, image height in pixels (>=2).
REQ-003 SHALL derive localparams COL_W=$clog2(WIDTH), ROW_W=$clog2(HEIGHT), CNT_W=$clog2(WIDTH*HEIGHT+1).
REQ-004 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  frame start request, sampled in IDLE only.
REQ-007 SHALL have port abort  input  1  synchronous frame abort, any state.
REQ-008 SHALL have port stall_i  input  1  downstream not ready; freezes pixel issue.
REQ-009 SHALL have port mac_vld_i  input  1  vld_o of MAC lane 0 (one pulse per accepted window).
REQ-010 SHALL have port ctrl_data_run  output  1  window issue strobe to MAC array (drives vld_i).
REQ-011 SHALL have port row  output  ROW_W  current window centre row.
REQ-012 SHALL have port col  output  COL_W  current window centre column.
REQ-013 SHALL have port busy_o  output  1  high in any state except IDLE.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse after last MAC result returned.
REQ-015 SHALL have port err_o  output  1  sticky: mac_vld_i seen with no outstanding window.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DRAIN, DONE, registered.
REQ-017 IDLE->RUN when start=1 and abort=0; row, col, issue and return counters cleared on that edge.
REQ-018 ctrl_data_run SHALL equal (state==RUN) & ~stall_i, combinationally.
REQ-019 In RUN with ctrl_data_run=1: col increments; at col==WIDTH-1, col wraps to 0 and row increments.
REQ-020 In RUN with stall_i=1: row, col, issue counter hold; no window issued.
REQ-021 RUN->DRAIN on the cycle the window at (HEIGHT-1, WIDTH-1) is issued; row/col hold at that position afterwards.
REQ-022 Return counter SHALL increment on every mac_vld_i in RUN or DRAIN; outstanding = issued - returned, CNT_W bits.
REQ-023 DRAIN->DONE when a mac_vld_i brings returned to WIDTH*HEIGHT; same condition in RUN (zero-latency MAC) goes RUN->DONE directly after last issue.
REQ-024 DONE SHALL last exactly one cycle with frame_done=1, then ->IDLE; frame_done=0 in all other states.
REQ-025 abort=1 in any state SHALL force IDLE next cycle, no frame_done, counters cleared; abort beats start.
REQ-026 start while busy_o=1 SHALL be ignored (no restart, no queueing).
REQ-027 mac_vld_i with outstanding==0, or in IDLE/DONE, SHALL set err_o and not change the return counter; err_o cleared only by rst.
REQ-028 Total issue cycles per unstalled frame SHALL be exactly WIDTH*HEIGHT; stalls add cycles one-for-one.

Reset
REQ-029 On rst=1 at a clock edge: state=IDLE, row=0, col=0, counters=0, err_o=0; ctrl_data_run=0, busy_o=0, frame_done=0 from the following cycle.
REQ-030 rst SHALL override abort, start and all other inputs, including mid-frame.

Structure
REQ-031 FSM state encoding and default WIDTH/HEIGHT SHALL live in shared package cnv_pkg, also used by cnv.
REQ-032 Row/column scan SHALL be a sub-module cnv_scan_cnt (enable, clear, row, col, last flag); FSM, return counting and error logic stay in cnv_ctrl.
REQ-033 cnv_ctrl SHALL contain no image storage or arithmetic beyond counters.

Verification (WIDTH=4, HEIGHT=3, bench MAC model latency 2)
REQ-034 start pulse cycle 0, no stall -> ctrl_data_run cycles 1..12, (row,col) (0,0)..(2,3) row-major, frame_done only at cycle 15, busy_o low cycle 16.
REQ-035 stall_i high cycles 3..5 -> (row,col) holds (0,2) during stall, 12 issues total, frame_done at cycle 18.
REQ-036 abort at cycle 7 -> IDLE cycle 8, no frame_done, late mac_vld_i pulses set err_o=1.
REQ-037 start held high continuously -> second frame begins cycle 17 (IDLE one cycle), start during frame ignored.
REQ-038 rst at cycle 6 mid-frame -> all outputs 0 from cycle 7; fresh start completes a normal 12-window frame.
REQ-039 spurious mac_vld_i in IDLE -> err_o=1 sticky; subsequent frame still completes with frame_done.
